// File: rtl/game_flow_controller.sv
// Game sequencer for the brick-breaker: level load, serve delay, play, pause and win/lose.
// Owns the remaining brick health and lives counters; every output comes from a register.
module game_flow_controller #(
  parameter int HEALTH_W     = 10,
  parameter int START_LIVES  = 3,
  parameter int SERVE_DELAY  = 60,
  parameter int LOAD_TIMEOUT = 1023
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start_btn,
  input  logic                pause_btn,
  input  logic                load_done,
  input  logic [HEALTH_W-1:0] level_health,
  input  logic                brick_hit,
  input  logic [1:0]          hit_damage,
  input  logic                ball_lost,
  output logic                load_start,
  output logic                play_enable,
  output logic                serve_active,
  output logic [HEALTH_W-1:0] health_remaining,
  output logic [1:0]          lives,
  output logic                win_occurred,
  output logic                game_over,
  output logic                load_error,
  output logic [2:0]          state
);

  localparam logic [2:0] IDLE  = 3'd0;
  localparam logic [2:0] LOAD  = 3'd1;
  localparam logic [2:0] SERVE = 3'd2;
  localparam logic [2:0] PLAY  = 3'd3;
  localparam logic [2:0] PAUSE = 3'd4;
  localparam logic [2:0] WIN   = 3'd5;
  localparam logic [2:0] LOSE  = 3'd6;

  // One counter is shared by LOAD and SERVE, so size it for the longer of the two.
  localparam int CNT_MAX = (LOAD_TIMEOUT > SERVE_DELAY) ? LOAD_TIMEOUT : SERVE_DELAY;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam logic [CNT_W-1:0] LOAD_LAST  = CNT_W'(LOAD_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] SERVE_LAST = CNT_W'(SERVE_DELAY - 1);

  logic [2:0]          state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [HEALTH_W-1:0] health_q, health_d;
  logic [1:0]          lives_q, lives_d;
  logic                loadErr_q, loadErr_d;
  logic                loadStart_q, loadStart_d;
  logic [HEALTH_W-1:0] damage;
  logic [HEALTH_W-1:0] hitHealth;
  logic                startGame;

  // Saturating subtraction of the current hit from the remaining health.
  always_comb begin
    damage    = HEALTH_W'(hit_damage);
    hitHealth = (health_q > damage) ? (health_q - damage) : '0;
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    health_d    = health_q;
    lives_d     = lives_q;
    loadErr_d   = loadErr_q;
    loadStart_d = 1'b0;
    startGame   = 1'b0;

    case (state_q)
      IDLE: begin
        if (start_btn) startGame = 1'b1;
      end

      LOAD: begin
        if (load_done) begin
          health_d = level_health;
          cnt_d    = '0;
          state_d  = (level_health == '0) ? WIN : SERVE;
        end else if (cnt_q == LOAD_LAST) begin
          loadErr_d = 1'b1;
          cnt_d     = '0;
          state_d   = IDLE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      SERVE: begin
        if (cnt_q == SERVE_LAST) begin
          cnt_d   = '0;
          state_d = PLAY;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      // A hit is applied before a simultaneous ball loss; clearing the level wins outright.
      PLAY: begin
        if (brick_hit) health_d = hitHealth;
        if (brick_hit && (hitHealth == '0)) begin
          state_d = WIN;
        end else if (ball_lost) begin
          if (lives_q > 2'd1) begin
            lives_d = lives_q - 2'd1;
            cnt_d   = '0;
            state_d = SERVE;
          end else begin
            lives_d = 2'd0;
            state_d = LOSE;
          end
        end else if (pause_btn) begin
          state_d = PAUSE;
        end
      end

      PAUSE: begin
        if (start_btn)      startGame = 1'b1;
        else if (pause_btn) state_d   = PLAY;
      end

      WIN, LOSE: begin
        if (start_btn) startGame = 1'b1;
      end

      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase

    if (startGame) begin
      state_d     = LOAD;
      cnt_d       = '0;
      lives_d     = 2'(START_LIVES);
      loadErr_d   = 1'b0;
      loadStart_d = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      health_q    <= '0;
      lives_q     <= 2'd0;
      loadErr_q   <= 1'b0;
      loadStart_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      health_q    <= health_d;
      lives_q     <= lives_d;
      loadErr_q   <= loadErr_d;
      loadStart_q <= loadStart_d;
    end
  end

  assign load_start       = loadStart_q;
  assign play_enable      = (state_q == PLAY);
  assign serve_active     = (state_q == SERVE);
  assign win_occurred     = (state_q == WIN);
  assign game_over        = (state_q == LOSE);
  assign health_remaining = health_q;
  assign lives            = lives_q;
  assign load_error       = loadErr_q;
  assign state            = state_q;

endmodule

// File: tb/tb_game_flow_controller.sv
// Directed bench for game_flow_controller with hand-computed expectations
// checked by immediate assertions.
module tb_game_flow_controller;

  logic       clk = 1'b0;
  logic       reset;
  logic       start_btn, pause_btn, load_done, brick_hit, ball_lost;
  logic [9:0] level_health;
  logic [1:0] hit_damage;
  logic       load_start, play_enable, serve_active, win_occurred, game_over, load_error;
  logic [9:0] health_remaining;
  logic [1:0] lives;
  logic [2:0] state;

  int checkCount = 0;
  int failCount  = 0;

  game_flow_controller #(
    .HEALTH_W(10), .START_LIVES(3), .SERVE_DELAY(60), .LOAD_TIMEOUT(1023)
  ) dut (
    .clk(clk), .reset(reset), .start_btn(start_btn), .pause_btn(pause_btn),
    .load_done(load_done), .level_health(level_health), .brick_hit(brick_hit),
    .hit_damage(hit_damage), .ball_lost(ball_lost), .load_start(load_start),
    .play_enable(play_enable), .serve_active(serve_active),
    .health_remaining(health_remaining), .lives(lives), .win_occurred(win_occurred),
    .game_over(game_over), .load_error(load_error), .state(state)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checkCount++;
    assert (obs === exp) else begin
      failCount++;
      $error("[TB] FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // One-cycle pulse on the selected inputs, then everything back to idle.
  task automatic applyStimulus(input logic st, input logic pb, input logic ld, input logic [9:0] lh,
                               input logic bh, input logic [1:0] dmg, input logic bl);
    start_btn = st; pause_btn = pb; load_done = ld; level_health = lh;
    brick_hit = bh; hit_damage = dmg; ball_lost = bl;
    tick();
    start_btn = 0; pause_btn = 0; load_done = 0; level_health = '0;
    brick_hit = 0; hit_damage = '0; ball_lost = 0;
  endtask

  // Called in the first SERVE cycle; counts SERVE cycles until PLAY.
  task automatic waitServe(input string tag);
    int n = 0;
    while (serve_active && n < 200) begin
      n++;
      tick();
    end
    checkOutput({tag, "_serveLen"}, n, 60);
    checkOutput({tag, "_play"}, play_enable, 1);
  endtask

  task automatic startAndLoad(input string tag, input logic [9:0] lh);
    applyStimulus(1, 0, 0, '0, 0, 0, 0);
    checkOutput({tag, "_loadState"}, state, 1);
    checkOutput({tag, "_loadStart"}, load_start, 1);
    checkOutput({tag, "_lives"}, lives, 3);
    applyStimulus(0, 0, 1, lh, 0, 0, 0);
    checkOutput({tag, "_loadStartGone"}, load_start, 0);
    checkOutput({tag, "_health"}, health_remaining, lh);
  endtask

  initial begin
    int n;
    reset = 1;
    start_btn = 0; pause_btn = 0; load_done = 0; level_health = '0;
    brick_hit = 0; hit_damage = '0; ball_lost = 0;
    tick(); tick();
    checkOutput("rst_state", state, 0);
    checkOutput("rst_health", health_remaining, 0);
    checkOutput("rst_lives", lives, 0);
    checkOutput("rst_loadErr", load_error, 0);
    checkOutput("rst_loadStart", load_start, 0);
    checkOutput("rst_play", play_enable, 0);
    reset = 0;
    tick();

    // Win by three damage-2 hits on a health-5 level
    startAndLoad("g1", 10'd5);
    checkOutput("g1_serve", serve_active, 1);
    waitServe("g1");
    applyStimulus(0, 0, 0, '0, 1, 2'd2, 0);
    checkOutput("g1_hit1", health_remaining, 3);
    applyStimulus(0, 0, 0, '0, 1, 2'd2, 0);
    checkOutput("g1_hit2", health_remaining, 1);
    checkOutput("g1_notWinYet", win_occurred, 0);
    applyStimulus(0, 0, 0, '0, 1, 2'd2, 0);
    checkOutput("g1_hit3", health_remaining, 0);
    checkOutput("g1_win", win_occurred, 1);
    checkOutput("g1_winState", state, 5);
    checkOutput("g1_playOff", play_enable, 0);

    // Lose all three lives on a health-100 level
    startAndLoad("g2", 10'd100);
    waitServe("g2a");
    applyStimulus(0, 0, 0, '0, 1, 2'd0, 0);
    checkOutput("g2_zeroDmg", health_remaining, 100);
    applyStimulus(0, 0, 0, '0, 0, 0, 1);
    checkOutput("g2_lives2", lives, 2);
    checkOutput("g2_reserve", state, 2);
    waitServe("g2b");
    applyStimulus(0, 0, 0, '0, 0, 0, 1);
    checkOutput("g2_lives1", lives, 1);
    waitServe("g2c");
    applyStimulus(0, 0, 0, '0, 0, 0, 1);
    checkOutput("g2_lives0", lives, 0);
    checkOutput("g2_gameOver", game_over, 1);
    checkOutput("g2_loseState", state, 6);

    // Pause freezes counters, then reset mid-PLAY
    startAndLoad("g3", 10'd40);
    waitServe("g3");
    applyStimulus(0, 0, 0, '0, 1, 2'd3, 0);
    checkOutput("g3_hit", health_remaining, 37);
    applyStimulus(0, 1, 0, '0, 0, 0, 0);
    checkOutput("g3_pause", state, 4);
    checkOutput("g3_pausePlay", play_enable, 0);
    applyStimulus(0, 0, 0, '0, 1, 2'd3, 1);
    checkOutput("g3_frozenHealth", health_remaining, 37);
    checkOutput("g3_frozenLives", lives, 3);
    checkOutput("g3_stillPaused", state, 4);
    applyStimulus(0, 1, 0, '0, 0, 0, 0);
    checkOutput("g3_resume", state, 3);
    applyStimulus(0, 0, 0, '0, 0, 0, 1);
    waitServe("g3b");
    checkOutput("g3_lives2", lives, 2);
    #2 reset = 1;
    #1;
    checkOutput("g3_asyncState", state, 0);
    checkOutput("g3_asyncHealth", health_remaining, 0);
    checkOutput("g3_asyncLives", lives, 0);
    checkOutput("g3_asyncPlay", play_enable, 0);
    tick();
    reset = 0;
    tick();

    // Simultaneous final hit and ball loss: the win takes precedence
    startAndLoad("g4", 10'd1);
    waitServe("g4a");
    applyStimulus(0, 0, 0, '0, 0, 0, 1);
    waitServe("g4b");
    applyStimulus(0, 0, 0, '0, 0, 0, 1);
    waitServe("g4c");
    checkOutput("g4_lives1", lives, 1);
    applyStimulus(0, 0, 0, '0, 1, 2'd1, 1);
    checkOutput("g4_winState", state, 5);
    checkOutput("g4_livesKept", lives, 1);
    checkOutput("g4_noGameOver", game_over, 0);

    // Load timeout, recovery and an empty level
    applyStimulus(1, 0, 0, '0, 0, 0, 0);
    n = 0;
    while (state == 3'd1 && n < 2000) begin
      n++;
      tick();
    end
    checkOutput("g5_loadLen", n, 1023);
    checkOutput("g5_idle", state, 0);
    checkOutput("g5_loadErr", load_error, 1);
    applyStimulus(1, 0, 0, '0, 0, 0, 0);
    checkOutput("g5_errCleared", load_error, 0);
    checkOutput("g5_reload", state, 1);
    applyStimulus(0, 0, 1, 10'd0, 0, 0, 0);
    checkOutput("g5_emptyWin", state, 5);
    checkOutput("g5_winFlag", win_occurred, 1);

    $display("%0d/%0d checks passed", checkCount - failCount, checkCount);
    $finish;
  end

endmodule

// File: doc/game_flow_controller.md
Name: game_flow_controller

Overview:
- Top-level game sequencer for the brick-breaker game: drives the level loader, serve delay, play, pause and end-of-game phases.
- Owns the remaining-brick-health and lives counters. Issues win/lose, all synchronous to the pixel/game clock.
- Sits between user buttons, the level loader, the collision engine (brick_hit/ball_lost) and the draw/ball datapaths (play_enable).

Parameters:
- HEALTH_W, 10, width of health counters.
- START_LIVES, 3, lives loaded at game start (1..3).
- SERVE_DELAY, 60, cycles spent in SERVE before the ball is released (>=1).
- LOAD_TIMEOUT, 1023, max cycles in LOAD waiting for load_done.

Ports:
- clk  in  1  game clock
- reset  in  1  asynchronous, active-high reset
- start_btn  in  1  level, one-cycle pulse expected; starts or restarts a game
- pause_btn  in  1  one-cycle pulse; toggles PLAY/PAUSE
- load_done  in  1  one-cycle pulse from level loader
- level_health  in  HEALTH_W  total brick health; valid only when load_done=1
- brick_hit  in  1  one-cycle pulse from collision engine
- hit_damage  in  2  damage of current hit; valid with brick_hit; 0 = no damage
- ball_lost  in  1  one-cycle pulse; ball passed paddle
- load_start  out  1  one-cycle pulse requesting level load
- play_enable  out  1  high only in PLAY
- serve_active  out  1  high only in SERVE
- health_remaining  out  HEALTH_W  remaining brick health
- lives  out  2  remaining lives
- win_occurred  out  1  high in WIN
- game_over  out  1  high in LOSE
- load_error  out  1  sticky; LOAD timed out
- state  out  3  encoded state (debug)

Behaviour:
- Interface: one clock, clk. Reset is asynchronous and active-high, on port reset. Every register clears immediately on reset assertion.
- Reset values:
  - state=IDLE(0); health_remaining=0; lives=0; load_error=0.
  - All pulse/flag outputs 0.
- States (encoding): IDLE=0, LOAD=1, SERVE=2, PLAY=3, PAUSE=4, WIN=5, LOSE=6. The value 7 is illegal and goes to IDLE next cycle.
- Registered outputs: all outputs are registered or decoded from registered state, so there is no combinational path from any input to any output.
- IDLE:
  - start_btn causes the next state to be LOAD.
  - In that same transition cycle: lives<=START_LIVES, load_error<=0, load_start pulses for exactly 1 cycle (the first cycle in LOAD).
- LOAD:
  - A cycle counter starts at 0 on entry.
  - On load_done:
    - health_remaining<=level_health.
    - If level_health==0, go to WIN.
    - Otherwise go to SERVE.
  - If the counter reaches LOAD_TIMEOUT without load_done: load_error<=1, go to IDLE.
  - brick_hit, ball_lost and pause_btn are ignored.
- SERVE:
  - Counter runs 0..SERVE_DELAY-1, then the state goes to PLAY. SERVE lasts exactly SERVE_DELAY cycles.
  - All hit/lost/pause inputs are ignored.
- PLAY:
  - brick_hit: health_remaining <= health_remaining - hit_damage, saturating at 0.
    - If the result is 0, go to WIN next cycle.
    - hit_damage=0 leaves the counter unchanged.
  - ball_lost:
    - If lives>1: lives<=lives-1, go to SERVE.
    - If lives==1: lives<=0, go to LOSE.
  - Simultaneous brick_hit and ball_lost: the hit is applied first.
    - If health becomes 0, go to WIN and ignore the ball loss (lives unchanged).
    - Otherwise the ball_lost rule applies.
  - pause_btn: go to PAUSE. Priority WIN > ball_lost > pause.
- PAUSE:
  - play_enable=0. Counters are frozen; brick_hit and ball_lost are ignored.
  - pause_btn returns to PLAY.
  - start_btn restarts: go to LOAD, same actions as from IDLE.
- WIN / LOSE:
  - Hold. win_occurred=1 or game_over=1 respectively.
  - start_btn goes to LOAD (new game, same actions as from IDLE).
- start_btn in LOAD, SERVE or PLAY is ignored.
- Reset mid-operation returns to IDLE immediately. A pending load_start pulse is dropped.

Test Plan:
- Reset asserted mid-PLAY (health=40, lives=2) -> same cycle: state=0, health_remaining=0, lives=0, play_enable=0. Release, then start_btn -> load_start high exactly 1 cycle, state=1.
- Load level_health=5, wait SERVE_DELAY=60 -> serve_active high for exactly 60 cycles, then play_enable=1. Hits with damage 2, 2, 2 -> health 3, 1, 0 (saturated). win_occurred=1 the cycle after the third hit.
- START_LIVES=3, health=100: three ball_lost pulses (each after SERVE completes) -> lives 2, 1, then game_over=1 with lives=0.
- In PLAY, health=1, lives=1: brick_hit(damage 1) and ball_lost in the same cycle -> WIN, lives stays 1, game_over stays 0.
- pause_btn in PLAY -> state=4, play_enable=0. brick_hit/ball_lost during PAUSE leave health/lives unchanged. pause_btn -> state=3.
- start_btn, no load_done for LOAD_TIMEOUT cycles -> load_error=1, state=0. Next start_btn clears load_error. load_done with level_health=0 -> WIN.
